// File: rtl/instruction_fetch.sv
// instruction_fetch
// -----------------
// Instruction fetch stage of a five-stage pipeline. The stage owns the
// program counter, talks to instruction memory, and feeds the IF/ID
// pipeline register.
//
// Three states:
//   BOOT  - one quiet cycle after reset with no memory request.
//   FETCH - requests the word at PC. When memory answers, the word goes
//           straight through to the IF/ID register with no added latency.
//   HOLD  - IF/ID is stalled and the fetched word has been captured
//           locally. The word is re-presented until the stall releases.
//
// Branch and jump redirects come from ID. They flush IF/ID in the same
// cycle and load the new PC with the low two bits cleared. A redirect
// outranks a stall and a pending memory answer. A taken branch outranks
// a jump.
//
// Parameters
//   RESET_VECTOR                 PC value loaded while RESET is low.
// Ports
//   CLOCK                        rising-edge system clock
//   RESET                        asynchronous, active-low reset
//   STALL                        hazard-unit stall of IF/ID
//   BranchTaken, BranchTarget    branch redirect from ID
//   Jump, JumpTarget             jump redirect from ID
//   IMemReady, IMemData          instruction memory response
//   IMemRequest, IMemAddress     instruction memory request (address = PC)
//   Instruction_OUT              instruction to IF/ID (0 = bubble)
//   InstructionAddressPlus4_OUT  PC+4 of the presented instruction
//   FetchValid                   Instruction_OUT is a real instruction
//   FetchStall                   waiting on instruction memory
//   FlushIFID                    flush request to IF/ID on redirect
//   FetchCount                   instructions accepted by IF/ID
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic        IMemRequest,
  output logic [31:0] IMemAddress,
  output logic [31:0] Instruction_OUT,
  output logic [31:0] InstructionAddressPlus4_OUT,
  output logic        FetchValid,
  output logic        FetchStall,
  output logic        FlushIFID,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  fetch_state_t state, state_next;

  logic [31:0] pc, pc_next;
  logic [31:0] hold_reg, hold_reg_next;
  logic [31:0] fetch_count, fetch_count_next;

  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_target;

  // PC+4 wraps naturally in 32 bits, so 32'hFFFFFFFC + 4 gives 0.
  assign pc_plus4 = pc + 32'd4;

  // BOOT ignores redirects. ID has nothing valid yet, so any redirect
  // seen there is left over from before reset.
  assign redirect = (state != BOOT) && (BranchTaken || Jump);

  // Branch beats jump. The target is forced to word alignment.
  assign redirect_target = BranchTaken ? {BranchTarget[31:2], 2'b00}
                                       : {JumpTarget[31:2], 2'b00};

  assign IMemAddress = pc;
  assign FetchCount  = fetch_count;

  // State and datapath registers. Reset is asynchronous, so a reset in
  // the middle of FETCH or HOLD drops the in-flight word immediately and
  // leaves nothing that could still be counted.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      hold_reg    <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      hold_reg    <= hold_reg_next;
      fetch_count <= fetch_count_next;
    end
  end

  // Next-state and output decode. Every output defaults to an idle,
  // bubble-carrying value. Each state then overrides only what it
  // actually drives, so FlushIFID and FetchStall stay low except in
  // their own cases.
  always_comb begin
    state_next                  = state;
    pc_next                     = pc;
    hold_reg_next               = hold_reg;
    fetch_count_next            = fetch_count;
    IMemRequest                 = 1'b0;
    Instruction_OUT             = 32'd0;
    InstructionAddressPlus4_OUT = 32'd0;
    FetchValid                  = 1'b0;
    FetchStall                  = 1'b0;
    FlushIFID                   = 1'b0;

    unique case (state)
      BOOT: begin
        state_next = FETCH;
      end

      FETCH: begin
        IMemRequest = 1'b1;
        if (redirect) begin
          // A redirect discards whatever memory returns this cycle. It
          // also wins over a stall, because the word in IF/ID is on the
          // wrong path anyway.
          FlushIFID     = 1'b1;
          pc_next       = redirect_target;
          hold_reg_next = 32'd0;
          state_next    = FETCH;
        end else if (!IMemReady) begin
          FetchStall = 1'b1;
        end else begin
          Instruction_OUT             = IMemData;
          InstructionAddressPlus4_OUT = pc_plus4;
          FetchValid                  = 1'b1;
          if (STALL) begin
            // IF/ID cannot take the word this cycle. Keep it locally so
            // memory does not have to be asked again.
            hold_reg_next = IMemData;
            state_next    = HOLD;
          end else begin
            pc_next          = pc_plus4;
            fetch_count_next = fetch_count + 32'd1;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          FlushIFID     = 1'b1;
          pc_next       = redirect_target;
          hold_reg_next = 32'd0;
          state_next    = FETCH;
        end else begin
          Instruction_OUT             = hold_reg;
          InstructionAddressPlus4_OUT = pc_plus4;
          FetchValid                  = 1'b1;
          if (!STALL) begin
            pc_next          = pc_plus4;
            fetch_count_next = fetch_count + 32'd1;
            state_next       = FETCH;
          end
        end
      end

      default: begin
        state_next = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch
// --------------------
// Directed testbench for instruction_fetch. Inputs change 1 time unit
// after each rising edge. Outputs are sampled at the following falling
// edge, or a short delay after an asynchronous reset edge.
module tb_instruction_fetch;

  logic        CLOCK;
  logic        RESET;
  logic        STALL;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic        IMemRequest;
  logic [31:0] IMemAddress;
  logic [31:0] Instruction_OUT;
  logic [31:0] InstructionAddressPlus4_OUT;
  logic        FetchValid;
  logic        FetchStall;
  logic        FlushIFID;
  logic [31:0] FetchCount;

  int checks_total;
  int checks_passed;

  instruction_fetch #(.RESET_VECTOR(32'h00000000)) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .STALL(STALL),
    .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget),
    .Jump(Jump),
    .JumpTarget(JumpTarget),
    .IMemReady(IMemReady),
    .IMemData(IMemData),
    .IMemRequest(IMemRequest),
    .IMemAddress(IMemAddress),
    .Instruction_OUT(Instruction_OUT),
    .InstructionAddressPlus4_OUT(InstructionAddressPlus4_OUT),
    .FetchValid(FetchValid),
    .FetchStall(FetchStall),
    .FlushIFID(FlushIFID),
    .FetchCount(FetchCount)
  );

  // 10-unit clock.
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Drives one full set of stage inputs.
  task automatic applyStimulus(input logic stall, input logic br,
                               input logic [31:0] brt, input logic jmp,
                               input logic [31:0] jt, input logic rdy,
                               input logic [31:0] data);
    STALL        = stall;
    BranchTaken  = br;
    BranchTarget = brt;
    Jump         = jmp;
    JumpTarget   = jt;
    IMemReady    = rdy;
    IMemData     = data;
  endtask

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
  endtask

  // Advances to 1 unit after the next rising edge.
  task automatic nextCycle();
    @(posedge CLOCK);
    #1;
  endtask

  // Waits for the falling edge so outputs are stable.
  task automatic sample();
    @(negedge CLOCK);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    RESET = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);

    // Reset state.
    repeat (2) @(posedge CLOCK);
    #1;
    checkOutput("rst_addr",  IMemAddress, 32'h0);
    checkOutput("rst_req",   {31'd0, IMemRequest}, 32'd0);
    checkOutput("rst_instr", Instruction_OUT, 32'd0);
    checkOutput("rst_valid", {31'd0, FetchValid}, 32'd0);
    checkOutput("rst_p4",    InstructionAddressPlus4_OUT, 32'd0);
    checkOutput("rst_count", FetchCount, 32'd0);

    // Release reset. The stage spends one cycle in BOOT.
    RESET = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hA0A0A0A0);
    sample();
    checkOutput("boot_req",   {31'd0, IMemRequest}, 32'd0);
    checkOutput("boot_valid", {31'd0, FetchValid}, 32'd0);
    checkOutput("boot_instr", Instruction_OUT, 32'd0);

    // Sequential fetch at 0, 4 with zero-latency pass-through.
    nextCycle();
    sample();
    checkOutput("f0_addr",  IMemAddress, 32'h0);
    checkOutput("f0_req",   {31'd0, IMemRequest}, 32'd1);
    checkOutput("f0_instr", Instruction_OUT, 32'hA0A0A0A0);
    checkOutput("f0_valid", {31'd0, FetchValid}, 32'd1);
    checkOutput("f0_p4",    InstructionAddressPlus4_OUT, 32'h4);
    checkOutput("f0_fstall", {31'd0, FetchStall}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hA4A4A4A4);
    sample();
    checkOutput("f1_addr",  IMemAddress, 32'h4);
    checkOutput("f1_count", FetchCount, 32'd1);

    // Memory not ready for two cycles at PC=8.
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'hDEADBEEF);
    for (int i = 0; i < 2; i++) begin
      sample();
      checkOutput($sformatf("wait%0d_addr", i),  IMemAddress, 32'h8);
      checkOutput($sformatf("wait%0d_fstall", i), {31'd0, FetchStall}, 32'd1);
      checkOutput($sformatf("wait%0d_instr", i), Instruction_OUT, 32'd0);
      checkOutput($sformatf("wait%0d_valid", i), {31'd0, FetchValid}, 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hA8A8A8A8);
    sample();
    checkOutput("f2_addr",  IMemAddress, 32'h8);
    checkOutput("f2_instr", Instruction_OUT, 32'hA8A8A8A8);
    checkOutput("f2_count", FetchCount, 32'd2);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h8C220004);
    sample();
    checkOutput("f3_addr",  IMemAddress, 32'hC);
    checkOutput("f3_count", FetchCount, 32'd3);
    checkOutput("f3_instr", Instruction_OUT, 32'h8C220004);

    // STALL held: the word is captured and re-presented from HOLD.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h11111111);
    for (int i = 0; i < 2; i++) begin
      sample();
      checkOutput($sformatf("hold%0d_instr", i), Instruction_OUT, 32'h8C220004);
      checkOutput($sformatf("hold%0d_req", i),   {31'd0, IMemRequest}, 32'd0);
      checkOutput($sformatf("hold%0d_valid", i), {31'd0, FetchValid}, 32'd1);
      checkOutput($sformatf("hold%0d_addr", i),  IMemAddress, 32'hC);
      checkOutput($sformatf("hold%0d_p4", i),    InstructionAddressPlus4_OUT, 32'h10);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h11111111);
    sample();
    checkOutput("hrel_instr", Instruction_OUT, 32'h8C220004);
    checkOutput("hrel_count", FetchCount, 32'd3);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h00000103, 1'b1, 32'h00000200, 1'b1, 32'h22222222);
    sample();
    checkOutput("after_hold_addr",  IMemAddress, 32'h10);
    checkOutput("after_hold_count", FetchCount, 32'd4);
    checkOutput("after_hold_req",   {31'd0, IMemRequest}, 32'd1);

    // Branch and jump together with STALL: branch wins and IF/ID flushes.
    checkOutput("redir_flush", {31'd0, FlushIFID}, 32'd1);
    checkOutput("redir_instr", Instruction_OUT, 32'd0);
    checkOutput("redir_valid", {31'd0, FetchValid}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'd0);
    sample();
    checkOutput("br_addr",  IMemAddress, 32'h100);
    checkOutput("br_count", FetchCount, 32'd4);

    // Jump to a misaligned address near the top, then wrap PC+4.
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h33333333);
    sample();
    checkOutput("top_addr",  IMemAddress, 32'hFFFFFFFC);
    checkOutput("top_p4",    InstructionAddressPlus4_OUT, 32'h0);
    checkOutput("top_flush", {31'd0, FlushIFID}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h44444444);
    sample();
    checkOutput("wrap_addr",  IMemAddress, 32'h0);
    checkOutput("wrap_count", FetchCount, 32'd5);

    // Jump taken while in HOLD.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'h00000040, 1'b0, 32'd0);
    sample();
    checkOutput("hjmp_flush", {31'd0, FlushIFID}, 32'd1);
    checkOutput("hjmp_valid", {31'd0, FetchValid}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h55555555);
    sample();
    checkOutput("hjmp_addr",  IMemAddress, 32'h40);
    checkOutput("hjmp_count", FetchCount, 32'd5);
    checkOutput("hjmp_req",   {31'd0, IMemRequest}, 32'd1);

    // Enter HOLD, then apply asynchronous reset between clock edges.
    nextCycle();
    sample();
    checkOutput("pre_rst_valid", {31'd0, FetchValid}, 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    checkOutput("arst_addr",  IMemAddress, 32'h0);
    checkOutput("arst_count", FetchCount, 32'd0);
    checkOutput("arst_valid", {31'd0, FetchValid}, 32'd0);
    checkOutput("arst_instr", Instruction_OUT, 32'd0);
    nextCycle();
    RESET = 1'b1;

    // A redirect seen in BOOT is ignored.
    applyStimulus(1'b0, 1'b1, 32'h00000080, 1'b0, 32'd0, 1'b1, 32'h66666666);
    sample();
    checkOutput("boot_flush", {31'd0, FlushIFID}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h66666666);
    sample();
    checkOutput("boot2_addr",  IMemAddress, 32'h0);
    checkOutput("boot2_instr", Instruction_OUT, 32'h66666666);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h00000000, the PC loaded on reset.
REQ-002 SHALL have port CLOCK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port STALL  input  1  hazard-unit stall; the IF/ID register holds its contents.
REQ-005 SHALL have port BranchTaken  input  1  branch resolved taken in ID.
REQ-006 SHALL have port BranchTarget  input  32  branch destination address.
REQ-007 SHALL have port Jump  input  1  jump resolved in ID.
REQ-008 SHALL have port JumpTarget  input  32  jump destination address.
REQ-009 SHALL have port IMemReady  input  1  instruction memory returns data this cycle.
REQ-010 SHALL have port IMemData  input  32  instruction word from memory.
REQ-011 SHALL have port IMemRequest  output  1  fetch request to instruction memory.
REQ-012 SHALL have port IMemAddress  output  32  fetch address (current PC).
REQ-013 SHALL have port Instruction_OUT  output  32  instruction to IF/ID; 0 is a NOP bubble.
REQ-014 SHALL have port InstructionAddressPlus4_OUT  output  32  PC+4 of the presented instruction to IF/ID.
REQ-015 SHALL have port FetchValid  output  1  Instruction_OUT carries a real instruction.
REQ-016 SHALL have port FetchStall  output  1  waiting on memory; informs the hazard unit.
REQ-017 SHALL have port FlushIFID  output  1  drives the IF/ID FLUSH input on redirect.
REQ-018 SHALL have port FetchCount  output  32  count of instructions accepted by IF/ID.

Function
REQ-019 SHALL implement states BOOT, FETCH and HOLD; BOOT -> FETCH unconditionally after one cycle.
REQ-020 BOOT SHALL drive IMemRequest=0, FetchValid=0 and Instruction_OUT=0.
REQ-021 FETCH SHALL drive IMemRequest=1 and IMemAddress=PC.
REQ-022 FETCH with IMemReady=0 SHALL assert FetchStall=1, output a bubble (Instruction_OUT=0, FetchValid=0) and hold PC.
REQ-023 FETCH with IMemReady=1 SHALL present IMemData on Instruction_OUT combinationally (zero-cycle latency) with FetchValid=1 and InstructionAddressPlus4_OUT=PC+4.
REQ-024 FETCH with IMemReady=1 and STALL=0: PC <= PC+4, FetchCount increments, and the state stays FETCH.
REQ-025 FETCH with IMemReady=1 and STALL=1: IMemData is latched into a hold register, PC is held, and the state goes to HOLD.
REQ-026 HOLD SHALL drive IMemRequest=0 and present the hold register with FetchValid=1 and InstructionAddressPlus4_OUT=PC+4.
REQ-027 HOLD with STALL=0: PC <= PC+4, FetchCount increments, and the state goes to FETCH.
REQ-028 A redirect is BranchTaken or Jump asserted in FETCH or HOLD; redirects are ignored in BOOT.
REQ-029 On redirect: PC <= target, FlushIFID=1 (combinational, same cycle), Instruction_OUT=0, FetchValid=0, hold register discarded, next state FETCH, no FetchCount increment.
REQ-030 Redirect SHALL take priority over STALL and over IMemReady.
REQ-031 BranchTaken SHALL take priority over Jump when both are asserted.
REQ-032 Targets SHALL have bits [1:0] forced to 00 when loaded into PC.
REQ-033 PC+4 and FetchCount SHALL wrap modulo 2^32 (32'hFFFFFFFC + 4 = 0).
REQ-034 FlushIFID and FetchStall SHALL be 0 outside the conditions stated above.

Reset
REQ-035 RESET low SHALL immediately force PC=RESET_VECTOR, state=BOOT, hold register=0 and FetchCount=0, regardless of CLOCK.
REQ-036 During and after reset all outputs SHALL read 0 except IMemAddress=RESET_VECTOR, until the first FETCH cycle.
REQ-037 Reset asserted mid-fetch or mid-HOLD SHALL abandon the in-flight instruction with no FetchCount change.

Verification
REQ-038 Reset release, IMemReady=1, STALL=0 -> IMemAddress sequence 0, 4, 8; FetchCount = 3 after three FETCH cycles.
REQ-039 IMemReady=0 for 2 cycles at PC=8 -> FetchStall=1 and Instruction_OUT=0 for 2 cycles, PC stays 8, then data at PC=8 is delivered.
REQ-040 STALL=1 for 3 cycles as data 32'h8C220004 arrives -> HOLD presents 32'h8C220004 all 3 cycles with IMemRequest=0; PC advances once on release.
REQ-041 BranchTaken=1, BranchTarget=32'h00000103, Jump=1, STALL=1 simultaneously -> FlushIFID=1, next PC=32'h00000100, FetchCount unchanged.
REQ-042 PC=32'hFFFFFFFC accepted -> next PC=0, InstructionAddressPlus4_OUT=0.
REQ-043 RESET low while in HOLD -> asynchronous return to BOOT, PC=RESET_VECTOR, FetchCount=0.
